shiftby2_32b: RTL and testbench

- Registered left-shift-by-2 unit for the single-cycle datapath.
- Converts a word offset (sign-extended branch immediate or jump index) into a byte offset by multiplying by 4.
- Sits between the sign-extender and the branch-target adder.
- One pipeline register with a valid/ready handshake; also reports the bits that were shifted out.

---
 rtl/shiftby2_pkg.sv | 15 +
 rtl/shiftby2_comb.sv | 59 +++++
 rtl/shiftby2_32b.sv | 126 ++++++++++++
 tb/tb_shiftby2_32b.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/shiftby2_pkg.sv
// ---------------------------------------------------------------------------
// shiftby2_pkg
//   Shared defaults for the word-to-byte offset shifter.
//   WORD_W     : datapath word width (bits)
//   BYTE_SHIFT : left-shift amount that turns a word offset into a byte offset
//   word_t     : one datapath word
// ---------------------------------------------------------------------------
package shiftby2_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_SHIFT = 2;

  typedef logic [WORD_W-1:0] word_t;

endpackage : shiftby2_pkg

// File: rtl/shiftby2_comb.sv
// ---------------------------------------------------------------------------
// shiftby2_comb
//   Pure combinational part of the offset shifter: constant left shift with
//   zero fill, extraction of the bits pushed out the top, and (optionally)
//   a signed-overflow flag.
//
//   Configuration macro: SHIFTBY2_OVERFLOW_EN
//     defined   -> ovf_o port exists and flags a signed result that does not fit
//     undefined -> ovf_o port is absent, no overflow logic exists
//
//   Ports:
//     data_i    [WIDTH-1:0]  operand
//     shifted_o [WIDTH-1:0]  data_i << SHIFT, zero filled
//     lost_o    [SHIFT-1:0]  data_i[WIDTH-1 -: SHIFT]
//     ovf_o                  top SHIFT+1 bits of data_i are not uniform
//                            (only with SHIFTBY2_OVERFLOW_EN)
//
//   Parameter constraints: 1 <= SHIFT < WIDTH.
// ---------------------------------------------------------------------------
module shiftby2_comb
  import shiftby2_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SHIFT = BYTE_SHIFT
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] shifted_o,
`ifdef SHIFTBY2_OVERFLOW_EN
  output logic             ovf_o,
`endif
  output logic [SHIFT-1:0] lost_o
);

  // Bit-level wiring: the low SHIFT positions are zero, every other output
  // bit is the input bit SHIFT places below it. No rotation, no sign fill.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi < SHIFT) begin : g_fill
        assign shifted_o[gi] = 1'b0;
      end else begin : g_move
        assign shifted_o[gi] = data_i[gi-SHIFT];
      end
    end
  endgenerate

  // The bits that fall off the top of the word.
  assign lost_o = data_i[WIDTH-1 -: SHIFT];

`ifdef SHIFTBY2_OVERFLOW_EN
  // The shifted value keeps its sign only when the discarded bits and the
  // new sign bit all equal the original sign, i.e. the top SHIFT+1 bits
  // are uniform. Anything else is a signed overflow.
  logic [SHIFT:0] top_bits;
  assign top_bits = data_i[WIDTH-1 -: SHIFT+1];
  assign ovf_o    = !((top_bits == '0) || (top_bits == '1));
`endif

endmodule : shiftby2_comb

// File: rtl/shiftby2_32b.sv
// ---------------------------------------------------------------------------
// shiftby2_32b
//   Registered left-shift-by-SHIFT unit turning a word offset (sign-extended
//   branch immediate or jump index) into a byte offset. One output register
//   with a valid/ready handshake; also reports the shifted-out bits.
//
//   Configuration macro: SHIFTBY2_OVERFLOW_EN
//     defined   -> overflow is a registered signed-overflow flag
//     undefined -> overflow is tied to 0, no overflow logic is built
//
//   Ports:
//     clk        in   sole clock, rising edge
//     rst        in   synchronous active-high reset
//     data_in    in   [WIDTH-1:0] operand
//     in_valid   in   data_in valid this cycle
//     in_ready   out  unit can take an operand this cycle (combinational)
//     data_out   out  [WIDTH-1:0] registered data_in << SHIFT
//     lost_bits  out  [SHIFT-1:0] registered data_in[WIDTH-1 -: SHIFT]
//     out_valid  out  data_out / lost_bits / overflow are valid
//     out_ready  in   consumer takes the result this cycle
//     overflow   out  registered signed-overflow flag (0 when disabled)
// ---------------------------------------------------------------------------
module shiftby2_32b
  import shiftby2_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SHIFT = BYTE_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [SHIFT-1:0] lost_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  // -------------------------------------------------------------------------
  // Combinational shift
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] shifted;
  logic [SHIFT-1:0] lost;
`ifdef SHIFTBY2_OVERFLOW_EN
  logic             ovf;
`endif

  shiftby2_comb #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT)
  ) u_comb (
    .data_i    (data_in),
    .shifted_o (shifted),
`ifdef SHIFTBY2_OVERFLOW_EN
    .ovf_o     (ovf),
`endif
    .lost_o    (lost)
  );

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic             out_valid_q;
  logic             out_valid_d;
  logic             accept;
  logic [WIDTH-1:0] data_q;
  logic [SHIFT-1:0] lost_q;

  // The register is free when empty or being drained this very cycle, which
  // gives one operand per cycle when the consumer never stalls.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      // Covers plain load and simultaneous drain+reload alike.
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

  // Data registers are clock-enabled by accept only, so they hold during a
  // stall and never sample data_in while in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      lost_q <= '0;
    end else if (accept) begin
      data_q <= shifted;
      lost_q <= lost;
    end
  end

`ifdef SHIFTBY2_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (accept) begin
      overflow_q <= ovf;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign lost_bits = lost_q;

endmodule : shiftby2_32b

// File: tb/tb_shiftby2_32b.sv
// ---------------------------------------------------------------------------
// tb_shiftby2_32b
//   Scoreboard bench: the driver pushes the reference result whenever an
//   operand is accepted; an independent monitor on the falling edge pops and
//   compares whenever the DUT hands over a result, and also checks out_valid
//   timing, in_ready and stall stability.
// ---------------------------------------------------------------------------
module tb_shiftby2_32b;
  import shiftby2_pkg::*;

  typedef struct packed {
    word_t      data;
    logic [1:0] lost;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  word_t      data_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  word_t      data_out;
  logic [1:0] lost_bits;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       overflow;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  bit   acc_now = 1'b0;
  bit   mon_en  = 1'b0;

  shiftby2_32b dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .lost_bits (lost_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: multiply by four in 64-bit arithmetic and keep the low word;
  // the lost bits are the quotient by 2^30; overflow means the signed
  // product is outside the 32-bit signed range.
  function automatic exp_t model(input word_t d);
    exp_t   e;
    longint prod_u;
    longint prod_s;
    prod_u = longint'({32'b0, d}) * 4;
    prod_s = longint'(signed'(d)) * 4;
    e.data = prod_u[31:0];
    e.lost = 2'(d / 32'h4000_0000);
`ifdef SHIFTBY2_OVERFLOW_EN
    e.ovf  = (prod_s > 64'sd2147483647) || (prod_s < -64'sd2147483648);
`else
    e.ovf  = (prod_s != prod_s); // always 0: feature disabled
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the expected result is queued on accept.
  task automatic step(input logic v, input word_t d, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    data_in   = d;
    out_ready = r;
    #1;
    acc_now = v && in_ready;
    if (acc_now) begin
      sb.push_back(model(d));
      $display("drive  data_in=%h out_ready=%0b accepted", d, r);
    end
  endtask

  // Reset while offering an operand with the consumer ready, so a
  // same-cycle accept must lose to reset.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b1;
    data_in   = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    acc_now   = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out",  data_out,       32'd0);
    chk("rst_lost_bits", 32'(lost_bits), 32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
  endtask

  // Monitor
  bit    stall_prev = 1'b0;
  word_t held_data;
  logic [1:0] held_lost;
  logic  held_ovf;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      stall_prev = 1'b0;
    end else begin
      exp_t e;
      chk("out_valid_timing", 32'(out_valid), 32'((sb.size() - int'(acc_now)) > 0));
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stall_prev) begin
        chk("stall_data", data_out,       held_data);
        chk("stall_lost", 32'(lost_bits), 32'(held_lost));
        chk("stall_ovf",  32'(overflow),  32'(held_ovf));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h want none", data_out);
        end else begin
          e = sb.pop_front();
          chk("data_out",  data_out,       e.data);
          chk("lost_bits", 32'(lost_bits), 32'(e.lost));
          chk("overflow",  32'(overflow),  32'(e.ovf));
          $display("output data_out=%h lost=%b ovf=%0b expect=%h", data_out, lost_bits, overflow, e.data);
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = data_out;
      held_lost  = lost_bits;
      held_ovf   = overflow;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    word_t corners[6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h3FFF_FFFF;
    corners[3] = 32'hC000_0001;
    corners[4] = 32'h4000_0000;
    corners[5] = 32'hE000_0000;

    // Reset state
    repeat (2) @(posedge clk);
    do_reset();
    mon_en = 1'b1;

    // First operand and one-cycle latency
    step(1'b1, 32'h0000_0004, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Back-to-back stream keeps in_ready high
    step(1'b1, 32'h0000_0022, 1'b1);
    chk("stream_in_ready0", 32'(in_ready), 32'd1);
    step(1'b1, 32'h0000_004C, 1'b1);
    chk("stream_in_ready1", 32'(in_ready), 32'd1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Boundary operands
    foreach (corners[i]) step(1'b1, corners[i], 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Backpressure: hold one result, a second operand must be refused
    step(1'b1, 32'h0000_0001, 1'b0);
    step(1'b1, 32'h0000_0055, 1'b0);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 32'h0000_0066, 1'b0);
    chk("stall_in_ready2", 32'(in_ready), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a stall drops the held result
    step(1'b1, 32'h0000_0007, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    do_reset();

    // Randomised traffic with occasional corner operands
    for (int n = 0; n < 2000; n++) begin
      word_t d;
      d = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : word_t'($urandom);
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0);
    end

    // Drain everything that is still queued
    repeat (6) step(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shiftby2_32b
